// File: rtl/mem_arb_pkg.sv
// Shared encodings and helpers for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  // Smallest width that can hold maxCount; never below one bit.
  function automatic int cntWidth(input int maxCount);
    int w;
    w = 1;
    while ((64'd1 << w) <= 64'(maxCount)) w++;
    return w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_grant.sv
// Grant decision for the shared memory port: D first, with an optional
// anti-starvation counter for I enabled by MEM_ARB_STARVE_GUARD_EN.
module mem_arb_grant
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_STARVE_GUARD_EN
  input  logic   clk,
  input  logic   reset,
`endif
  input  logic   grant_en_i,
  input  logic   dm_req_i,
  input  logic   if_req_i,
  output owner_t grant_o
);

`ifdef MEM_ARB_STARVE_GUARD_EN
  parameter int MAX_D_BURST = 4;

  localparam int BW = cntWidth(MAX_D_BURST);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_D_BURST);

  logic [BW-1:0] burstCnt_q;
  logic          starved;

  assign starved = (burstCnt_q == BURST_MAX);

  always_comb begin
    grant_o = OWN_NONE;
    if (grant_en_i) begin
      if (if_req_i && (!dm_req_i || starved)) grant_o = OWN_I;
      else if (dm_req_i)                      grant_o = OWN_D;
    end
  end

  // Counts D grants that made a waiting fetch wait longer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burstCnt_q <= '0;
    end else if (grant_o == OWN_I) begin
      burstCnt_q <= '0;
    end else if (grant_o == OWN_D) begin
      if (!if_req_i)                    burstCnt_q <= '0;
      else if (burstCnt_q != BURST_MAX) burstCnt_q <= burstCnt_q + 1'b1;
    end
  end
`else
  always_comb begin
    grant_o = OWN_NONE;
    if (grant_en_i) begin
      if (dm_req_i)      grant_o = OWN_D;
      else if (if_req_i) grant_o = OWN_I;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported memory shared between fetch (I) and load/store (D).
// Optional starve guard for fetches: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_D_BURST = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  output logic                if_stall,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ready,
  output logic                dm_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_err
);

  localparam int TW = cntWidth(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t              state_q;
  owner_t              grant_d;
  logic [TW-1:0]       tcnt_q;
  logic                memReq_q, memWe_q, ifReady_q, dmReady_q, busErr_q;
  logic [ADDR_W-1:0]   memAddr_q;
  logic [DATA_W-1:0]   memWdata_q, ifRdata_q, dmRdata_q;
  logic [DATA_W/8-1:0] memWstrb_q;
  logic                grantEn, expire;

  // No grant in a ready cycle, so a requester that just completed is never
  // re-served on the request it is about to withdraw.
  assign grantEn = (state_q == IDLE) && !(ifReady_q || dmReady_q);
  assign expire  = (TIMEOUT != 0) && (tcnt_q == T_LAST);

  mem_arb_grant
`ifdef MEM_ARB_STARVE_GUARD_EN
    #(.MAX_D_BURST(MAX_D_BURST))
`endif
    u_grant (
`ifdef MEM_ARB_STARVE_GUARD_EN
    .clk        (clk),
    .reset      (reset),
`endif
    .grant_en_i (grantEn),
    .dm_req_i   (dm_req),
    .if_req_i   (if_req),
    .grant_o    (grant_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tcnt_q     <= '0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      memWstrb_q <= '0;
      ifRdata_q  <= '0;
      dmRdata_q  <= '0;
      ifReady_q  <= 1'b0;
      dmReady_q  <= 1'b0;
      busErr_q   <= 1'b0;
    end else begin
      ifReady_q <= 1'b0;
      dmReady_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tcnt_q <= '0;
          if (grant_d == OWN_D) begin
            state_q    <= BUSY_D;
            memReq_q   <= 1'b1;
            memWe_q    <= dm_we;
            memAddr_q  <= dm_addr;
            memWdata_q <= dm_wdata;
            memWstrb_q <= dm_we ? dm_wstrb : '0;
          end else if (grant_d == OWN_I) begin
            state_q    <= BUSY_I;
            memReq_q   <= 1'b1;
            memWe_q    <= 1'b0;
            memAddr_q  <= if_addr;
            memWdata_q <= '0;
            memWstrb_q <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          // An ack arriving on the expiry cycle still counts as success.
          if (mem_ack || expire) begin
            state_q  <= IDLE;
            memReq_q <= 1'b0;
            if (!mem_ack) busErr_q <= 1'b1;
            if (state_q == BUSY_I) begin
              ifRdata_q <= mem_ack ? mem_rdata : '0;
              ifReady_q <= 1'b1;
            end else begin
              if (!mem_ack)     dmRdata_q <= '0;
              else if (!memWe_q) dmRdata_q <= mem_rdata;
              dmReady_q <= 1'b1;
            end
          end else if (tcnt_q != '1) begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_rdata  = ifRdata_q;
  assign if_ready  = ifReady_q;
  assign if_stall  = if_req && !ifReady_q;
  assign dm_rdata  = dmRdata_q;
  assign dm_ready  = dmReady_q;
  assign dm_stall  = dm_req && !dmReady_q;
  assign mem_req   = memReq_q;
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign mem_wstrb = memWstrb_q;
  assign bus_err   = busErr_q;

endmodule
